// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and default tick counts,
// used by both the transmit and receive paths.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int OS_TICK_DEF = 16;
    localparam int SB_TICK_DEF = 16;

    // Wide enough for a 2-stop-bit period of 32 ticks.
    localparam int TICK_W = 5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;

    function automatic logic [TICK_W-1:0] tick_last(input int n);
        return TICK_W'(n - 1);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Oversampling tick counter with synchronous clear and a
// terminal-count flag against a programmable last value.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [TICK_W-1:0] last,
    output logic              tc
);

    logic [TICK_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, D_BIT data bits LSB first, optional parity
// (UART_TX_PARITY_EN adds parity_odd input), stop period of SB_TICK ticks.
module uart_tx
    import uart_pkg::*;
#(
    parameter int D_BIT   = 8,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int OS_TICK = OS_TICK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic             s_tick,
`ifdef UART_TX_PARITY_EN
    input  logic             parity_odd,
`endif
    input  logic [D_BIT-1:0] din,
    output logic             tx_busy,
    output logic             tx_done_tick,
    output logic             tx
);

    localparam int BW = (D_BIT > 1) ? $clog2(D_BIT) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(D_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [BW-1:0]     n_q, n_d;
    logic [D_BIT-1:0]  b_q, b_d;
    logic              tx_q, tx_d;
    logic              clr;
    logic              tc;
    logic              bit_end;
    logic [TICK_W-1:0] last;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign last    = (state_q == STOP) ? tick_last(SB_TICK)
                                       : tick_last(OS_TICK);
    assign bit_end = s_tick & tc;

    uart_tx_bit_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (s_tick),
        .last (last),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        b_d          = b_q;
        clr          = 1'b0;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    b_d     = din;
                    clr     = 1'b1;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^din) ^ parity_odd;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    clr     = 1'b1;
                    n_d     = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clr = 1'b1;
                    b_d = b_q >> 1;
                    if (n_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clr     = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    clr          = 1'b1;
                    tx_done_tick = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx changes on the same
    // edge as the state register, straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_busy = (state_q != IDLE);
    assign tx      = tx_q;

endmodule
